// File: rtl/prbs31_checker.sv
// Serial PRBS31 (x^31 + x^28 + 1) checker: self-seeds from the received stream,
// verifies alignment, then flags and counts bit errors against a free-running reference.
module prbs31_checker #(
  parameter int ERR_W       = 16,
  parameter int LOCK_LEN    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int LC_W = $clog2(LOCK_LEN + 1);
  localparam int WC_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [LC_W-1:0] LOCK_LAST   = LC_W'(LOCK_LEN - 1);
  localparam logic [WC_W-1:0] WIN_LAST    = WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] THRESH_LAST = WE_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [30:0]     hist, hist_nxt;
  logic [4:0]      seed_cnt, seed_cnt_nxt;
  logic [LC_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [WC_W-1:0] win_cnt, win_cnt_nxt;
  logic [WE_W-1:0] win_err, win_err_nxt;
  logic            predicted, mismatch, lock_err;

  assign predicted = hist[27] ^ hist[30];
  assign mismatch  = bit_in ^ predicted;
  assign lock_err  = bit_valid && (state == LOCKED) && mismatch;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_nxt    = state;
    hist_nxt     = hist;
    seed_cnt_nxt = seed_cnt;
    lock_cnt_nxt = lock_cnt;
    win_cnt_nxt  = win_cnt;
    win_err_nxt  = win_err;
    if (bit_valid) begin
      unique case (state)
        SEED: begin
          hist_nxt = {hist[29:0], bit_in};
          if (seed_cnt == 5'd30) begin
            seed_cnt_nxt = '0;
            // An all-zero history is the LFSR lock-up state; keep collecting.
            if (hist_nxt != '0) begin
              state_nxt    = VERIFY;
              lock_cnt_nxt = '0;
            end
          end else begin
            seed_cnt_nxt = seed_cnt + 1'b1;
          end
        end
        VERIFY: begin
          hist_nxt = {hist[29:0], bit_in};
          if (mismatch) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state_nxt   = LOCKED;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 1'b1;
          end
        end
        LOCKED: begin
          // Self-feeding reference so a single line error is counted once.
          hist_nxt    = {hist[29:0], predicted};
          win_cnt_nxt = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
          if (mismatch && (win_err == THRESH_LAST)) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_err_nxt = '0;
          end else if (mismatch) begin
            win_err_nxt = win_err + 1'b1;
          end
        end
        default: state_nxt = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEED;
      hist     <= '0;
      seed_cnt <= '0;
      lock_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      seed_cnt <= seed_cnt_nxt;
      lock_cnt <= lock_cnt_nxt;
      win_cnt  <= win_cnt_nxt;
      win_err  <= win_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= lock_err;
      if (clr_cnt)
        err_count <= '0;
      else if (lock_err && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule
